// File: rtl/riscv_scoreboard_if.sv
// Decode-side handshake between the issue stage and the register scoreboard.
// The master drives candidate instructions, writeback and flush events. The slave answers with hazard status.
interface riscv_scoreboard_if #(
  parameter int unsigned NB_OPERAND = 5,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned NB_LAT     = 3
);
  localparam int unsigned NB_PEND = $clog2(NUM_REGS + 1);

  logic                  i_issue_valid;
  logic [NB_OPERAND-1:0] i_rs1;
  logic [NB_OPERAND-1:0] i_rs2;
  logic                  i_rs1_used;
  logic                  i_rs2_used;
  logic [NB_OPERAND-1:0] i_rd;
  logic                  i_rd_wr;
  logic [NB_LAT-1:0]     i_lat;
  logic                  i_wb_valid;
  logic [NB_OPERAND-1:0] i_wb_rd;
  logic                  i_flush;
  logic                  o_stall;
  logic                  o_busy_rs1;
  logic                  o_busy_rs2;
  logic [NB_PEND-1:0]    o_pending;

  modport master (
    output i_issue_valid, i_rs1, i_rs2, i_rs1_used, i_rs2_used,
           i_rd, i_rd_wr, i_lat, i_wb_valid, i_wb_rd, i_flush,
    input  o_stall, o_busy_rs1, o_busy_rs2, o_pending
  );

  modport slave (
    input  i_issue_valid, i_rs1, i_rs2, i_rs1_used, i_rs2_used,
           i_rd, i_rd_wr, i_lat, i_wb_valid, i_wb_rd, i_flush,
    output o_stall, o_busy_rs1, o_busy_rs2, o_pending
  );
endinterface

// File: rtl/riscv_scoreboard.sv
// Per-register countdown scoreboard for RV32I decode. It detects RAW and WAW hazards and tracks in-flight writes
// with fixed or writeback-terminated latency.
module riscv_scoreboard #(
  parameter int unsigned NB_OPERAND = 5,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned NB_LAT     = 3,
  parameter int unsigned FLUSH_AGE  = 2,
  parameter int unsigned NB_AGE     = 2
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  riscv_scoreboard_if.slave  sb
);
  localparam int unsigned         NB_PEND     = $clog2(NUM_REGS + 1);
  localparam logic [NB_LAT-1:0]   LAT_STICKY  = '1;
  localparam logic [NB_AGE-1:0]   AGE_MAX     = '1;
  localparam logic [NB_AGE-1:0]   FLUSH_AGE_W = NB_AGE'(FLUSH_AGE);

  logic [NB_LAT-1:0]  cnt     [NUM_REGS];
  logic [NB_LAT-1:0]  cnt_nxt [NUM_REGS];
  logic [NB_AGE-1:0]  age     [NUM_REGS];
  logic [NB_AGE-1:0]  age_nxt [NUM_REGS];
  logic [NB_PEND-1:0] pending;
  logic [NB_PEND-1:0] pending_nxt;

  logic busy_rs1;
  logic busy_rs2;
  logic waw;
  logic stall;
  logic accept;

  // Hazard detection reads only registered state, so the stall path is short.
  always_comb begin
    busy_rs1 = sb.i_issue_valid & sb.i_rs1_used & (sb.i_rs1 != '0) & (cnt[sb.i_rs1] != '0);
    busy_rs2 = sb.i_issue_valid & sb.i_rs2_used & (sb.i_rs2 != '0) & (cnt[sb.i_rs2] != '0);
    waw      = sb.i_issue_valid & sb.i_rd_wr & (sb.i_rd != '0) & (cnt[sb.i_rd] != '0) &
               ((cnt[sb.i_rd] == LAT_STICKY) | (cnt[sb.i_rd] > sb.i_lat));
    stall    = busy_rs1 | busy_rs2 | waw;
    accept   = sb.i_issue_valid & ~stall & ~sb.i_flush;
  end

  // Per-entry update, priority: flush kill, accept, sticky wb-clear, decrement.
  // Age counts cycles since issue while the entry is pending.
  always_comb begin
    cnt_nxt     = cnt;
    age_nxt     = age;
    pending_nxt = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      if ((cnt[r] != '0) && (age[r] != AGE_MAX)) begin
        age_nxt[r] = age[r] + NB_AGE'(1);
      end
      if (sb.i_flush && (cnt[r] != '0) && (age[r] < FLUSH_AGE_W)) begin
        cnt_nxt[r] = '0;
        age_nxt[r] = '0;
      end else if (accept && sb.i_rd_wr && (sb.i_rd == NB_OPERAND'(r)) && (sb.i_lat != '0)) begin
        cnt_nxt[r] = sb.i_lat;
        age_nxt[r] = '0;
      end else if (sb.i_wb_valid && (sb.i_wb_rd == NB_OPERAND'(r)) && (cnt[r] == LAT_STICKY)) begin
        cnt_nxt[r] = '0;
      end else if ((cnt[r] != '0) && (cnt[r] != LAT_STICKY)) begin
        cnt_nxt[r] = cnt[r] - NB_LAT'(1);
      end
      if (cnt_nxt[r] != '0) begin
        pending_nxt = pending_nxt + NB_PEND'(1);
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= '0;
        age[r] <= '0;
      end
      pending <= '0;
    end else begin
      cnt     <= cnt_nxt;
      age     <= age_nxt;
      pending <= pending_nxt;
    end
  end

  assign sb.o_stall    = stall;
  assign sb.o_busy_rs1 = busy_rs1;
  assign sb.o_busy_rs2 = busy_rs2;
  assign sb.o_pending  = pending;
endmodule

// File: tb/tb_riscv_scoreboard.sv
// Directed, table-driven check of riscv_scoreboard hazards, latency tracking, flush, writeback and reset.
module tb_riscv_scoreboard;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  riscv_scoreboard_if #(.NB_OPERAND(5), .NUM_REGS(32), .NB_LAT(3)) sbi ();

  riscv_scoreboard #(
    .NB_OPERAND(5), .NUM_REGS(32), .NB_LAT(3), .FLUSH_AGE(2), .NB_AGE(2)
  ) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .sb        (sbi)
  );

  typedef struct {
    logic       valid;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
    logic [2:0] lat;
    logic       wb;
    logic [4:0] wb_rd;
    logic       fl;
    logic       e_stall;
    logic       e_b1;
    logic       e_b2;
    int         e_pend;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input int valid, input int rs1, input int u1, input int rs2, input int u2,
                              input int rd, input int wr, input int lat, input int wb, input int wb_rd,
                              input int fl, input int es, input int eb1, input int eb2, input int ep);
    vec_t v;
    v.valid   = valid[0];
    v.rs1     = 5'(rs1);
    v.u1      = u1[0];
    v.rs2     = 5'(rs2);
    v.u2      = u2[0];
    v.rd      = 5'(rd);
    v.wr      = wr[0];
    v.lat     = 3'(lat);
    v.wb      = wb[0];
    v.wb_rd   = 5'(wb_rd);
    v.fl      = fl[0];
    v.e_stall = es[0];
    v.e_b1    = eb1[0];
    v.e_b2    = eb2[0];
    v.e_pend  = ep;
    return v;
  endfunction

  function automatic vec_t idle(input int ep);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ep);
  endfunction

  task automatic drive(input vec_t v);
    sbi.i_issue_valid = v.valid;
    sbi.i_rs1         = v.rs1;
    sbi.i_rs1_used    = v.u1;
    sbi.i_rs2         = v.rs2;
    sbi.i_rs2_used    = v.u2;
    sbi.i_rd          = v.rd;
    sbi.i_rd_wr       = v.wr;
    sbi.i_lat         = v.lat;
    sbi.i_wb_valid    = v.wb;
    sbi.i_wb_rd       = v.wb_rd;
    sbi.i_flush       = v.fl;
  endtask

  task automatic chk(input string nm, input int id, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0d, expected %0d", nm, id, act, exp);
    end
  endtask

  // One cycle: hazards checked mid-cycle, pending count checked just after the edge.
  task automatic run_vec(input int id, input vec_t v);
    drive(v);
    #2;
    chk("stall", id, int'(sbi.o_stall), int'(v.e_stall));
    chk("busy_rs1", id, int'(sbi.o_busy_rs1), int'(v.e_b1));
    chk("busy_rs2", id, int'(sbi.o_busy_rs2), int'(v.e_b2));
    @(posedge clk);
    #1;
    chk("pending", id, int'(sbi.o_pending), v.e_pend);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Fixed-latency RAW: x5 lat 2
    vecs.push_back(mk(1, 0, 0, 0, 0, 5, 1, 2, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 1, 1, 0, 1));
    vecs.push_back(mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    // Sticky load x7, ten stalled cycles, then writeback
    vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 7, 0, 0, 0, 0, 0, 0, 1));
    for (int k = 0; k < 10; k++) vecs.push_back(mk(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0, 7, 1, 0, 0, 0, 1, 7, 0, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Writeback to a non-sticky entry is ignored
    vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 3, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1));
    vecs.push_back(idle(0));
    // WAW on x3
    vecs.push_back(mk(1, 0, 0, 0, 0, 3, 1, 4, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 3, 1, 5, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 3, 1, 3, 1, 3, 1, 1, 0, 0, 0, 1, 1, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(idle(0));
    // Flush kills only young entries
    vecs.push_back(mk(1, 0, 0, 0, 0, 8, 1, 4, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(idle(1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 9, 1, 4, 0, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 9, 1, 8, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 10, 1, 3, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(idle(1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Young sticky entry killed by flush
    vecs.push_back(mk(1, 0, 0, 0, 0, 12, 1, 7, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // x0 never tracked; flush blocks a same-cycle issue
    vecs.push_back(mk(1, 0, 1, 0, 1, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 11, 1, 3, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Under reset nothing is pending, whatever the inputs
    drive(mk(1, 5, 1, 5, 1, 5, 1, 3, 0, 0, 0, 0, 0, 0, 0));
    #12;
    chk("rst_stall", 0, int'(sbi.o_stall), 0);
    chk("rst_pending", 0, int'(sbi.o_pending), 0);
    drive(idle(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_pending", 0, int'(sbi.o_pending), 0);

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // Asynchronous reset with five sticky entries outstanding
    for (int r = 1; r <= 5; r++) run_vec(100 + r, mk(1, 0, 0, 0, 0, r, 1, 7, 0, 0, 0, 0, 0, 0, r));
    drive(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    #2;
    chk("pre_areset_stall", 200, int'(sbi.o_stall), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("areset_stall", 201, int'(sbi.o_stall), 0);
    chk("areset_busy_rs1", 201, int'(sbi.o_busy_rs1), 0);
    chk("areset_pending", 201, int'(sbi.o_pending), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(202, mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
